// File: rtl/npu_mem_arbiter.sv
// rtl/npu_mem_arbiter.sv - shared data-memory arbiter between CPU MEM stage and NPU burst mover
// Optional feature macro: ARB_PERF_CNT_EN (adds saturating stall/critical cycle counters)
module npu_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int BURST_MAX  = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              npu_req,
  input  logic              npu_we,
  input  logic [ADDR_W-1:0] npu_base,
  input  logic [4:0]        npu_len,
  input  logic [DATA_W-1:0] npu_wdata,
  output logic              npu_gnt,
  output logic              npu_rvalid,
  output logic [DATA_W-1:0] npu_rdata,
  output logic              npu_done,
  output logic              critical,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_crit_cnt
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [4:0]    BURST_LIM  = 5'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, NPU_BURST, CPU_SLOT} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [4:0]        len_q, len_d;
  logic [4:0]        beat_q, beat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [SW-1:0]     wait_q, wait_d;
  logic              done_q, done_d;
  logic              cpu_rv_q, cpu_rv_d;
  logic              npu_rv_q, npu_rv_d;

  logic [4:0]        len_eff;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] npu_addr;
  logic              npu_wr;
  logic [SW-1:0]     starve_inc;
  logic              last_beat;

  // Normalise the requested burst length: 0 means one beat, oversize clamps
  always_comb begin
    len_eff = npu_len;
    if (npu_len == 5'd0) begin
      len_eff = 5'd1;
    end else if (npu_len > BURST_LIM) begin
      len_eff = BURST_LIM;
    end
  end

  // Arbitration, burst sequencing, conflict detection and memory port mux
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_d     = beat_q;
    starve_d   = starve_q;
    wait_d     = wait_q;
    done_d     = 1'b0;
    cpu_gnt    = 1'b0;
    npu_gnt    = 1'b0;
    npu_addr   = base_q + ADDR_W'(beat_q);
    npu_wr     = we_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    last_beat  = (beat_q + 5'd1 == len_q);
    starve_inc = (cpu_req && starve_q != STARVE_LIM) ? starve_q + SW'(1) : starve_q;
    // Wrap-aware range test: distance from burst base must lie in [beat, len-1]
    offset     = cpu_addr - base_q;
    critical   = !reset && (state_q != IDLE) && we_q && cpu_req &&
                 (offset >= ADDR_W'(beat_q)) && (offset < ADDR_W'(len_q));

    if (!reset) begin
      case (state_q)
        IDLE: begin
          starve_d = '0;
          if (npu_req && (!cpu_req || wait_q >= STARVE_LIM)) begin
            npu_gnt  = 1'b1;
            npu_addr = npu_base;
            npu_wr   = npu_we;
            we_d     = npu_we;
            base_d   = npu_base;
            len_d    = len_eff;
            beat_d   = 5'd1;
            wait_d   = '0;
            if (len_eff == 5'd1) begin
              done_d = 1'b1;
            end else begin
              state_d = NPU_BURST;
            end
          end else begin
            cpu_gnt = cpu_req;
            if (npu_req) begin
              wait_d = (wait_q != STARVE_LIM) ? wait_q + SW'(1) : wait_q;
            end else begin
              wait_d = '0;
            end
          end
        end
        default: begin
          // A slot blocked by a conflict turns back into an ordinary beat cycle
          if (state_q == CPU_SLOT && !critical) begin
            cpu_gnt  = cpu_req;
            starve_d = '0;
            state_d  = (beat_q >= len_q) ? IDLE : NPU_BURST;
          end else begin
            npu_gnt  = 1'b1;
            beat_d   = beat_q + 5'd1;
            starve_d = starve_inc;
            if (last_beat) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (cpu_req && starve_inc == STARVE_LIM && !critical) begin
              state_d = CPU_SLOT;
            end else begin
              state_d = NPU_BURST;
            end
          end
        end
      endcase
    end

    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (npu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = npu_wr;
      mem_addr  = npu_addr;
      mem_wdata = npu_wdata;
    end

    cpu_rv_d   = cpu_gnt && !cpu_we;
    npu_rv_d   = npu_gnt && !npu_wr;
    cpu_stall  = cpu_req && !cpu_gnt;
    cpu_rvalid = cpu_rv_q && !reset;
    npu_rvalid = npu_rv_q && !reset;
    npu_done   = done_q && !reset;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    npu_rdata  = npu_rvalid ? mem_rdata : '0;
  end

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= 5'd0;
      beat_q   <= 5'd0;
      starve_q <= '0;
      wait_q   <= '0;
      done_q   <= 1'b0;
      cpu_rv_q <= 1'b0;
      npu_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      base_q   <= base_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      cpu_rv_q <= cpu_rv_d;
      npu_rv_q <= npu_rv_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] crit_cnt_q, crit_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    crit_cnt_d  = crit_cnt_q;
    if (cpu_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (critical && crit_cnt_q != 16'hFFFF) crit_cnt_d = crit_cnt_q + 16'd1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      crit_cnt_q  <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      crit_cnt_q  <= crit_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_crit_cnt  = crit_cnt_q;
`endif

endmodule

// File: tb/tb_npu_mem_arbiter.sv
// tb/tb_npu_mem_arbiter.sv - directed scoreboard bench for npu_mem_arbiter
module tb_npu_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          npu_req, npu_we, npu_gnt, npu_rvalid, npu_done, critical;
  logic [AW-1:0] npu_base;
  logic [4:0]    npu_len;
  logic [DW-1:0] npu_wdata, npu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]   perf_stall_cnt, perf_crit_cnt;
`endif

  npu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .npu_req(npu_req), .npu_we(npu_we), .npu_base(npu_base), .npu_len(npu_len),
    .npu_wdata(npu_wdata), .npu_gnt(npu_gnt), .npu_rvalid(npu_rvalid), .npu_rdata(npu_rdata),
    .npu_done(npu_done), .critical(critical),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_crit_cnt(perf_crit_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] exp_mem [0:1023];

  // Synchronous memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t cq[$];
  exp_t nq[$];
  logic cur_we;

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 ^ 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cycle(input string tag, input bit cg, input bit ng, input bit crit,
                              input bit done, input logic [AW-1:0] addr);
    logic          wr;
    logic [DW-1:0] wd;
    exp_t          e;
    chk({tag, ".cpu_gnt"}, cpu_gnt, cg);
    chk({tag, ".npu_gnt"}, npu_gnt, ng);
    chk({tag, ".critical"}, critical, crit);
    chk({tag, ".npu_done"}, npu_done, done);
    chk({tag, ".cpu_stall"}, cpu_stall, cpu_req & ~cg);
    chk({tag, ".mem_en"}, mem_en, cg | ng);
    if (cg || ng) begin
      wr = cg ? cpu_we : cur_we;
      wd = cg ? cpu_wdata : npu_wdata;
      chk({tag, ".mem_addr"}, mem_addr, addr);
      chk({tag, ".mem_we"}, mem_we, wr);
      if (wr) begin
        chk({tag, ".mem_wdata"}, mem_wdata, wd);
        exp_mem[addr] = wd;
      end else begin
        e.due  = cyc + 1;
        e.data = exp_mem[addr];
        if (cg) cq.push_back(e);
        else nq.push_back(e);
      end
    end
  endtask

  // Read-return monitor: rvalid must appear exactly when a scoreboard entry falls due
  always @(negedge clk) begin
    #2;
    if (cq.size() > 0 && cq[0].due == cyc) begin
      chk("cpu_rvalid", cpu_rvalid, 1);
      chk("cpu_rdata", cpu_rdata, cq[0].data);
      void'(cq.pop_front());
    end else begin
      chk("cpu_rvalid_low", cpu_rvalid, 0);
    end
    if (nq.size() > 0 && nq[0].due == cyc) begin
      chk("npu_rvalid", npu_rvalid, 1);
      chk("npu_rdata", npu_rdata, nq[0].data);
      void'(nq.pop_front());
    end else begin
      chk("npu_rvalid_low", npu_rvalid, 0);
    end
  end

  // One NPU burst; optional CPU request from beat 1 with known conflict/slot points
  task automatic burst(input string tag, input bit we, input logic [AW-1:0] base,
                       input logic [4:0] len, input int beats, input bit use_cpu,
                       input logic [AW-1:0] caddr, input int crit_last, input int slot_at);
    bit            cpu_on;
    logic [AW-1:0] a;
    cpu_on = use_cpu;
    @(negedge clk);
    npu_req = 1; npu_we = we; npu_base = base; npu_len = len; cur_we = we;
    cpu_req = 0; cpu_we = 0; cpu_addr = caddr;
    npu_wdata = (32'(base) << 8) | 32'hD000_0000;
    #1;
    expect_cycle({tag, ".b0"}, 0, 1, 0, 0, base);
    for (int b = 1; b < beats; b++) begin
      @(negedge clk);
      npu_req = 0;
      cpu_req = cpu_on;
      npu_wdata = (32'(base) << 8) | 32'hD000_0000 | 32'(b);
      a = base + AW'(b);
      #1;
      expect_cycle({tag, ".beat"}, 0, 1, cpu_on && we && (b <= crit_last), 0, a);
      if (b == slot_at) begin
        @(negedge clk);
        #1;
        expect_cycle({tag, ".slot"}, 1, 0, 0, 0, caddr);
        cpu_on = 0;
      end
    end
    @(negedge clk);
    cpu_req = cpu_on;
    #1;
    expect_cycle({tag, ".done"}, cpu_on, 0, 0, 1, cpu_on ? caddr : '0);
    @(negedge clk);
    cpu_req = 0;
  endtask

  initial begin
    reset = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010; cpu_wdata = '0;
    npu_req = 1; npu_we = 0; npu_base = 10'h020; npu_len = 5'd0; npu_wdata = '0;
    cur_we = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] <= pat(i);
      exp_mem[i] = pat(i);
    end

    // Reset with both requests high
    repeat (2) begin
      @(negedge clk);
      #1;
      expect_cycle("reset", 0, 0, 0, 0, '0);
    end

    // Both requesting: CPU wins until the NPU wait counter reaches 8
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset = 0;
      cpu_addr = AW'(16 + i);
      #1;
      expect_cycle("idle_cpu", 1, 0, 0, 0, AW'(16 + i));
    end
    @(negedge clk);
    #1;
    expect_cycle("idle_npu_len0", 0, 1, 0, 0, 10'h020);
    @(negedge clk);
    npu_req = 0; cpu_req = 0;
    #1;
    expect_cycle("len1_done", 0, 0, 0, 1, '0);

    // Address wrap read burst
    burst("wrap", 0, 10'h3FE, 5'd4, 4, 0, '0, 0, 0);
    // Long read burst (oversize length clamps to 16) with CPU starvation slot
    burst("starve", 0, 10'h040, 5'd20, 16, 1, 10'h200, 0, 8);
    // Write burst conflicting with CPU read; CPU served after burst
    burst("conf4", 1, 10'h100, 5'd4, 4, 1, 10'h102, 2, 0);
    // Conflict persisting past the starvation limit; slot deferred until cleared
    burst("conf16", 1, 10'h180, 5'd16, 16, 1, 10'h18C, 12, 13);
    // Adjacent but non-conflicting address: served only via the slot
    burst("nocrit", 1, 10'h100, 5'd16, 16, 1, 10'h0FF, 0, 8);

    repeat (3) @(negedge clk);
    #3;
    chk("cpu_queue_drained", 64'(cq.size()), 0);
    chk("npu_queue_drained", 64'(nq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
